spi_dma_burst: RTL and testbench
================================

# spi_dma_burst

Parametrised burst DMA bridge between the SpeedSPI core and the Avalon-MM fabric. It is the next generation of the single-word SPI DMA engine. One command moves `cmd_len` consecutive words, read or write, starting at `cmd_addr`. Data streams through an internal FIFO with valid/ready handshakes, and reads are pipelined with credit-limited outstanding requests.

## Interface
- `ADDR_W`, 32: address width (bytes).
- `DATA_W`, 32: word width; multiple of 8.
- `LEN_W`, 8: width of the burst length field.
- `FIFO_DEPTH`, 4: data FIFO depth; power of two, ≥2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start byte address.
- `cmd_len` in LEN_W: number of words; 0 is legal.
- `wr_valid` in 1, `wr_data` in DATA_W, `wr_ready` out 1: write-data stream in.
- `rd_valid` out 1, `rd_data` out DATA_W, `rd_ready` in 1: read-data stream out.
- `done` out 1: one-cycle pulse at burst completion.
- `busy` out 1: high in every state except IDLE.
- `avm_m1_read` out 1, `avm_m1_write` out 1, `avm_m1_address` out ADDR_W, `avm_m1_writedata` out DATA_W: Avalon master outputs.
- `avm_m1_waitrequest` in 1, `avm_m1_readdatavalid` in 1, `avm_m1_readdata` in DATA_W: Avalon master inputs.

## Operation
- **States:** IDLE, RD, RD_DRAIN, WR, DONE.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch address, length and direction.
  - Reset the issued, returned and transferred counters.
  - Next state: `cmd_len`==0 → DONE; else `cmd_write` ? WR : RD.
- **Address:** start address plus `(DATA_W/8)` per issued word, modulo 2^ADDR_W, so it wraps silently.
- **RD:**
  - Assert `avm_m1_read` while issued<len and credit>0.
  - Credit = FIFO_DEPTH − (FIFO occupancy + outstanding reads). This guarantees the FIFO never overflows on `readdatavalid`.
  - A request is issued on a cycle with read=1 and waitrequest=0; the address then advances.
  - While waitrequest=1, address and read are held stable.
  - When issued==len, go to RD_DRAIN.
- **Read returns:** each `avm_m1_readdatavalid` pushes `avm_m1_readdata` into the FIFO and decrements outstanding.
  - `rd_valid` = FIFO non-empty; `rd_data` = FIFO head.
  - A pop happens when `rd_valid` && `rd_ready`.
- **RD_DRAIN:** when returned==len and the FIFO is empty, go to DONE.
- **WR:**
  - `wr_ready` = FIFO not full && accepted<len; each handshake pushes `wr_data`.
  - `avm_m1_write` = FIFO non-empty, with `avm_m1_writedata` = FIFO head.
  - When waitrequest=0, pop the head and advance the address.
  - When written==len, go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Stray inputs:**
  - `readdatavalid` in IDLE, WR or DONE is ignored (dropped, not stored).
  - `wr_valid` outside WR is ignored.
- **Simultaneous push and pop:** occupancy is unchanged. Push into a full FIFO never happens by construction. The bench asserts this.

## Timing
- **Reset values:**
  - All outputs 0.
  - `cmd_ready` is 1 in IDLE, so it reads 1 on the first cycle after reset.
  - FIFO is empty; counters and address are 0.
- **Avalon outputs:** combinational from registered state, FIFO and counters. No input-to-output combinational path except `wr_ready` and `rd_valid`, which depend only on registered FIFO state.
- **Command accept:** command accepted at edge N. In RD or WR, the first bus request appears in cycle N+1 (RD), or one cycle after the first write word enters the FIFO (WR).
- **Read data:** `readdatavalid` at edge K gives `rd_valid`=1 in cycle K+1.
- **Read throughput:** one request per cycle when waitrequest=0, credit permits and `rd_ready`=1.
- **`done` timing:**
  - Read: `done` is asserted the cycle after the last word is popped.
  - Write: `done` is asserted the cycle after the last write completes (waitrequest low).
  - len=0: `done` is asserted the cycle after accept.
- **Back-to-back commands:** the next command can be accepted the cycle after `done`.
- **Reset mid-burst:**
  - At the next edge, go to IDLE, clear the FIFO, outstanding count and counters.
  - Drop the bus request immediately.
  - Late `readdatavalid` responses are discarded.

## Test plan
- Read, len=1, addr 0x40, waitrequest high 2 cycles, data 0xDEADBEEF one cycle later:
  - `avm_m1_read` held with address 0x40 for 3 cycles.
  - `rd_data`=0xDEADBEEF.
  - `done` one cycle after the pop.
- Read, len=8, addr 0x1000, `rd_ready` low for the first 10 cycles, slave returning data with 1-cycle latency:
  - Never more than 4 outstanding plus buffered.
  - `avm_m1_read` drops at credit=0.
  - All 8 words are popped in order from addresses 0x1000–0x101C.
- Write, len=4, addr 0x100, words 1..4, waitrequest toggling:
  - Writes occur at 0x100, 0x104, 0x108, 0x10C with data 1..4.
  - `wr_ready` drops when the FIFO is full.
  - `done` after the 4th write.
- len=0 write command:
  - No `avm_m1_read` or `avm_m1_write` activity.
  - `done` asserted the cycle after accept.
  - `cmd_ready` high the cycle after that.
- Read, len=2, addr 0xFFFFFFFC: addresses issued are 0xFFFFFFFC then 0x00000000.
- `rst` asserted while a read burst is at 3 of 6 words, with 2 outstanding:
  - Outputs go to reset values next cycle.
  - The 2 late `readdatavalid` responses are ignored.
  - `rd_valid` stays 0.
  - A new len=1 read completes normally.

Source files
------------

// File: rtl/spi_dma_burst.sv
// Burst DMA bridge between SpeedSPI streams and an Avalon-MM master port.
// One shared FIFO buffers read returns or write data; reads are credit-limited so the FIFO cannot overflow.
module spi_dma_burst #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              done,
  output logic              busy,
  output logic              avm_m1_read,
  output logic              avm_m1_write,
  output logic [ADDR_W-1:0] avm_m1_address,
  output logic [DATA_W-1:0] avm_m1_writedata,
  input  logic              avm_m1_waitrequest,
  input  logic              avm_m1_readdatavalid,
  input  logic [DATA_W-1:0] avm_m1_readdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  iss_q, iss_d;  // reads issued / writes completed
  logic [LEN_W-1:0]  ret_q, ret_d;  // read returns accepted
  logic [LEN_W-1:0]  acc_q, acc_d;  // write words accepted
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d, out_q, out_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic rd_st, empty, full, credit_ok;
  logic rd_issue, rd_push, wr_push, push, rd_pop, wr_pop, pop;
  logic [DATA_W-1:0] push_data;

  assign rd_st     = (state_q == S_RD) || (state_q == S_DRAIN);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  // Outstanding reads already own a FIFO slot, so they count against credit.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH);

  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign avm_m1_read      = (state_q == S_RD) && (iss_q != len_q) && credit_ok;
  assign avm_m1_write     = (state_q == S_WR) && !empty;
  assign avm_m1_address   = addr_q;
  assign avm_m1_writedata = avm_m1_write ? mem_q[rp_q] : '0;
  assign wr_ready         = (state_q == S_WR) && !full && (acc_q != len_q);
  assign rd_valid         = rd_st && !empty;
  assign rd_data          = rd_valid ? mem_q[rp_q] : '0;

  assign rd_issue  = avm_m1_read && !avm_m1_waitrequest;
  // Returns with nothing outstanding (stray or post-reset) are dropped.
  assign rd_push   = rd_st && avm_m1_readdatavalid && (out_q != '0);
  assign wr_push   = wr_valid && wr_ready;
  assign push      = rd_push || wr_push;
  assign push_data = rd_st ? avm_m1_readdata : wr_data;
  assign rd_pop    = rd_valid && rd_ready;
  assign wr_pop    = avm_m1_write && !avm_m1_waitrequest;
  assign pop       = rd_pop || wr_pop;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    iss_d   = iss_q + LEN_W'(rd_issue || wr_pop);
    ret_d   = ret_q + LEN_W'(rd_push);
    acc_d   = acc_q + LEN_W'(wr_push);
    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    out_d   = out_q + CW'(rd_issue) - CW'(rd_push);
    if (rd_issue || wr_pop) addr_d = addr_q + ADDR_W'(DATA_W / 8);
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        iss_d   = '0;
        ret_d   = '0;
        acc_d   = '0;
        state_d = (cmd_len == '0) ? S_DONE : (cmd_write ? S_WR : S_RD);
      end
      S_RD:    if (iss_d == len_q) state_d = S_DRAIN;
      S_DRAIN: if ((ret_d == len_q) && (cnt_d == '0)) state_d = S_DONE;
      S_WR:    if (iss_d == len_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      acc_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wp_q] <= push_data;
  end
endmodule

// File: tb/tb_spi_dma_burst.sv
// Scoreboard bench for spi_dma_burst: directed commands push expectations, a monitor
// (which also plays the Avalon slave) pops and compares on each handshake.
module tb_spi_dma_burst;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [7:0]  cmd_len = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = 0;
  logic        rd_valid, rd_ready = 0;
  logic [31:0] rd_data;
  logic        done, busy;
  logic        avm_m1_read, avm_m1_write;
  logic [31:0] avm_m1_address, avm_m1_writedata;
  logic        avm_m1_waitrequest = 0, avm_m1_readdatavalid = 0;
  logic [31:0] avm_m1_readdata = 0;

  spi_dma_burst dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .done(done), .busy(busy),
    .avm_m1_read(avm_m1_read), .avm_m1_write(avm_m1_write),
    .avm_m1_address(avm_m1_address), .avm_m1_writedata(avm_m1_writedata),
    .avm_m1_waitrequest(avm_m1_waitrequest), .avm_m1_readdatavalid(avm_m1_readdatavalid),
    .avm_m1_readdata(avm_m1_readdata)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } resp_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  logic [31:0] exp_rd[$], exp_raddr[$];
  logic [63:0] exp_wr[$];
  resp_t resp[$];
  int lat = 1, stall_n = 0, acc_cyc = -100, last_evt = -100;
  logic toggle = 0, force_wait = 0;
  int fires = 0, outs = 0, bufc = 0, viol = 0, rd_cycles = 0, bus_act = 0, done_cnt = 0;

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor + Avalon slave model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        outs = 0; bufc = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin last_evt = cyc; acc_cyc = cyc; end
        if (avm_m1_read) rd_cycles++;
        if (avm_m1_read || avm_m1_write) bus_act++;
        if (avm_m1_read && !avm_m1_waitrequest) begin
          fires++; outs++;
          if (exp_raddr.size() == 0) chk("rd_addr_unexpected", 64'(avm_m1_address), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("rd_addr", 64'(avm_m1_address), 64'(exp_raddr.pop_front()));
          resp.push_back('{due: cyc + lat, data: rdmem(avm_m1_address)});
        end
        if (avm_m1_readdatavalid && outs > 0) begin outs--; bufc++; end
        if (rd_valid && rd_ready) begin
          bufc--; last_evt = cyc;
          if (exp_rd.size() == 0) chk("rd_data_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
        if (avm_m1_write && !avm_m1_waitrequest) begin
          last_evt = cyc;
          if (exp_wr.size() == 0) chk("wr_unexpected", {avm_m1_address, avm_m1_writedata}, 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("wr_addr_data", {avm_m1_address, avm_m1_writedata}, exp_wr.pop_front());
        end
        if (done) begin
          chk("done_timing", 64'(cyc), 64'(last_evt + 1));
          done_cnt++;
        end
        if (outs + bufc > 4) viol++;
      end
      @(posedge clk); #1;
      if (resp.size() > 0 && resp[0].due <= cyc) begin
        avm_m1_readdatavalid = 1; avm_m1_readdata = resp[0].data; void'(resp.pop_front());
      end else begin
        avm_m1_readdatavalid = 0; avm_m1_readdata = 0;
      end
      avm_m1_waitrequest = force_wait || (cyc <= acc_cyc + stall_n) || (toggle && cyc[0]);
    end
  end

  task automatic cmd(input logic w, input logic [31:0] a, input int n, input logic [31:0] wbase);
    int k = 0;
    @(posedge clk); #1;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (w) exp_wr.push_back({a + 32'(4 * i), wbase + 32'(i)});
      else begin
        exp_raddr.push_back(a + 32'(4 * i));
        exp_rd.push_back(rdmem(a + 32'(4 * i)));
      end
    end
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = 8'(n);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic put_word(input logic [31:0] v);
    int k = 0;
    wr_valid = 1; wr_data = v;
    @(negedge clk);
    while (!wr_ready && k < 200) begin @(negedge clk); k++; end
    if (!wr_ready) chk("wr_ready_timeout", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 300) begin @(negedge clk); #1; k++; end
    chk("done_seen", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    int rdv_bad;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outs", {busy, done, avm_m1_read, avm_m1_write, rd_valid, wr_ready}, 64'd0);

    // T1: single read, 2 wait cycles
    stall_n = 2; rd_ready = 1; rd_cycles = 0;
    cmd(0, 32'h40, 1, 0);
    wait_done(1);
    chk("t1_read_held", 64'(rd_cycles), 64'd3);

    // T2: len 8, consumer stalled 10 cycles: credit must stop issue at 4
    stall_n = 0; rd_ready = 0; fires = 0; viol = 0;
    cmd(0, 32'h1000, 8, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_fires_at_credit0", 64'(fires), 64'd4);
    chk("t2_read_dropped", 64'(avm_m1_read), 64'd0);
    rd_ready = 1;
    wait_done(2);
    chk("t2_credit_bound", 64'(viol), 64'd0);

    // T3: write len 4 with toggling waitrequest
    toggle = 1;
    cmd(1, 32'h100, 4, 32'd1);
    for (int i = 1; i <= 4; i++) put_word(32'(i));
    wait_done(3);
    toggle = 0;

    // T3b: write len 6 with slave stalled long enough to fill the FIFO
    stall_n = 8;
    cmd(1, 32'h200, 6, 32'h10);
    for (int i = 0; i < 4; i++) put_word(32'h10 + 32'(i));
    @(negedge clk);
    chk("t3b_wr_ready_full", 64'(wr_ready), 64'd0);
    chk("t3b_write_stalled", 64'(avm_m1_write), 64'd1);
    put_word(32'h14);
    put_word(32'h15);
    wait_done(4);
    stall_n = 0;

    // T4: zero-length write
    bus_act = 0;
    cmd(1, 32'h300, 0, 0);
    wait_done(5);
    @(negedge clk);
    chk("t4_cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    chk("t4_no_bus_activity", 64'(bus_act), 64'd0);

    // T5: address wrap
    cmd(0, 32'hFFFF_FFFC, 2, 0);
    wait_done(6);

    // T6: reset mid-burst with two responses still in flight
    lat = 3; rd_ready = 0; fires = 0;
    cmd(0, 32'h2000, 6, 0);
    begin
      int k = 0;
      while (fires < 3 && k < 100) begin @(posedge clk); #1; k++; end
    end
    chk("t6_fires_before_rst", 64'(fires), 64'd3);
    rst = 1; force_wait = 1;
    @(posedge clk); #1;
    rst = 0; force_wait = 0;
    exp_rd.delete(); exp_raddr.delete();
    rd_ready = 1;
    @(negedge clk);
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_rst_outs", {busy, done, avm_m1_read, avm_m1_write, rd_valid, wr_ready}, 64'd0);
    rdv_bad = 0;
    repeat (4) begin @(negedge clk); if (rd_valid) rdv_bad++; end
    chk("t6_late_returns_dropped", 64'(rdv_bad), 64'd0);
    lat = 1;
    cmd(0, 32'h80, 1, 0);
    wait_done(7);

    chk("end_rd_queue_empty", 64'(exp_rd.size() + exp_raddr.size()), 64'd0);
    chk("end_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
